// File: rtl/pool_unit_para_fp16.sv
// Multi-lane FP16 pooling unit: per-lane average or max over a k x k window, one shared FSM.
// Latency: result strobes 2 cycles after the n-th accepted beat (n+3 cycles start-to-result with no bubbles).
// Backpressure: none; beats are taken only in ACCUM when in_valid=1, all other in_valid/start are ignored.
module pool_unit_para_fp16 #(
    parameter int LANES           = 3,
    parameter int DATA_WIDTH      = 16,
    parameter int POOL_MAX        = 4,
    parameter int POOL_SIZE_WIDTH = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          mode,
    input  logic [POOL_SIZE_WIDTH-1:0]    pool_size,
    input  logic                          in_valid,
    input  logic [LANES*DATA_WIDTH-1:0]   in_data,
    output logic                          busy,
    output logic                          out_valid,
    output logic [LANES*DATA_WIDTH-1:0]   out_data,
    output logic                          cfg_err
);

    localparam int NMAX  = POOL_MAX * POOL_MAX;
    localparam int CNT_W = $clog2(NMAX + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, SCALE, DONE} state_t;

    // Round-to-nearest-even and pack. fr holds 10 fraction bits above guard/round/sticky.
    function automatic logic [15:0] fp16_pack(input logic sgn, input int exp_in, input logic [12:0] fr);
        logic [10:0] fr_r;
        logic        rnd;
        int          e;
        logic [15:0] res;
        rnd  = fr[2] & (fr[1] | fr[0] | fr[3]);
        fr_r = {1'b0, fr[12:3]} + 11'(rnd);
        e    = exp_in + int'(fr_r[10]);
        if (e >= 31)
            res = {sgn, 15'h7BFF};
        else if (e <= 0)
            res = {sgn, 15'h0000};
        else
            res = {sgn, e[4:0], fr_r[9:0]};
        return res;
    endfunction

    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] af, bf, x, y;
        logic [10:0] mx, my;
        logic [4:0]  d;
        logic [29:0] wide;
        logic [13:0] ax, ay;
        logic [14:0] s;
        logic [4:0]  lz;
        int          e;
        logic [15:0] res;
        af = (a[14:10] == 5'd0) ? {a[15], 15'h0} : a;
        bf = (b[14:10] == 5'd0) ? {b[15], 15'h0} : b;
        if (af[14:0] >= bf[14:0]) begin
            x = af; y = bf;
        end else begin
            x = bf; y = af;
        end
        res = 16'h0000;
        if (x[14:10] == 5'd0) begin
            res = {x[15] & y[15], 15'h0};
        end else if (y[14:10] == 5'd0) begin
            res = x;
        end else begin
            mx   = {1'b1, x[9:0]};
            my   = {1'b1, y[9:0]};
            d    = x[14:10] - y[14:10];
            wide = {my, 19'h0} >> d;
            ax   = {mx, 3'b000};
            ay   = wide[29:16] | {13'h0, |wide[15:0]};
            s    = (x[15] ^ y[15]) ? ({1'b0, ax} - {1'b0, ay}) : ({1'b0, ax} + {1'b0, ay});
            e    = int'(x[14:10]);
            if (s == 15'h0) begin
                res = 16'h0000;
            end else begin
                if (s[14]) begin
                    s = {1'b0, s[14:1]} | {14'h0, s[0]};
                    e = e + 1;
                end else begin
                    lz = 5'd0;
                    for (int i = 0; i <= 13; i++)
                        if (s[i]) lz = 5'(13 - i);
                    s = s << lz;
                    e = e - int'(lz);
                end
                res = fp16_pack(x[15], e, s[12:0]);
            end
        end
        return res;
    endfunction

    function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        logic        sgn;
        logic [21:0] p;
        logic [12:0] fr;
        int          e;
        logic [15:0] res;
        sgn = a[15] ^ b[15];
        if (a[14:10] == 5'd0 || b[14:10] == 5'd0) begin
            res = {sgn, 15'h0};
        end else begin
            p = {1'b1, a[9:0]} * {1'b1, b[9:0]};
            e = int'(a[14:10]) + int'(b[14:10]) - 15;
            if (p[21]) begin
                fr = {p[20:11], p[10], p[9], |p[8:0]};
                e  = e + 1;
            end else begin
                fr = {p[19:10], p[9], p[8], |p[7:0]};
            end
            res = fp16_pack(sgn, e, fr);
        end
        return res;
    endfunction

    // Sign-magnitude strictly-greater; +0 and -0 are equal.
    function automatic logic fp16_gt(input logic [15:0] x, input logic [15:0] a);
        logic r;
        if (x[14:0] == 15'h0 && a[14:0] == 15'h0)
            r = 1'b0;
        else if (x[15] != a[15])
            r = a[15];
        else if (x[15])
            r = x[14:0] < a[14:0];
        else
            r = x[14:0] > a[14:0];
        return r;
    endfunction

    function automatic logic [15:0] recip_lut(input logic [CNT_W-1:0] n);
        logic [15:0] r;
        case (int'(n))
            1:       r = 16'h3C00;
            2:       r = 16'h3800;
            3:       r = 16'h3555;
            4:       r = 16'h3400;
            5:       r = 16'h3266;
            6:       r = 16'h3155;
            7:       r = 16'h3092;
            8:       r = 16'h3000;
            9:       r = 16'h2F1C;
            10:      r = 16'h2E66;
            11:      r = 16'h2DD1;
            12:      r = 16'h2D55;
            13:      r = 16'h2CEC;
            14:      r = 16'h2C92;
            15:      r = 16'h2C44;
            16:      r = 16'h2C00;
            default: r = 16'h3C00;
        endcase
        return r;
    endfunction

    state_t                               state;
    logic                                 mode_r;
    logic [CNT_W-1:0]                     n_r;
    logic [CNT_W-1:0]                     cnt;
    logic [LANES-1:0][DATA_WIDTH-1:0]     acc;
    logic [LANES-1:0][DATA_WIDTH-1:0]     acc_nxt;
    logic [LANES-1:0][DATA_WIDTH-1:0]     scaled;
    logic [DATA_WIDTH-1:0]                recip;
    logic                                 size_ok;

    assign size_ok = (pool_size != '0) && (pool_size <= POOL_SIZE_WIDTH'(POOL_MAX));
    assign recip   = recip_lut(n_r);

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            logic [DATA_WIDTH-1:0] x;
            assign x          = in_data[g*DATA_WIDTH +: DATA_WIDTH];
            // First beat of a window loads the lane directly.
            assign acc_nxt[g] = (cnt == '0) ? x :
                                mode_r      ? (fp16_gt(x, acc[g]) ? x : acc[g]) :
                                              fp16_add(acc[g], x);
            assign scaled[g]  = mode_r ? acc[g] : fp16_mul(acc[g], recip);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mode_r    <= 1'b0;
            n_r       <= '0;
            cnt       <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            cfg_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            cfg_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (size_ok) begin
                            mode_r <= mode;
                            n_r    <= CNT_W'(pool_size) * CNT_W'(pool_size);
                            cnt    <= '0;
                            busy   <= 1'b1;
                            state  <= ACCUM;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc <= acc_nxt;
                        cnt <= cnt + CNT_W'(1);
                        if ((cnt + CNT_W'(1)) == n_r)
                            state <= SCALE;
                    end
                end
                SCALE: begin
                    acc       <= scaled;
                    out_data  <= scaled;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pool_unit_para_fp16.sv
// Scoreboard bench for pool_unit_para_fp16: expected windows queued at start, checked on out_valid.
module tb_pool_unit_para_fp16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [2:0]  pool_size;
    logic        in_valid;
    logic [47:0] in_data;
    logic        busy;
    logic        out_valid;
    logic [47:0] out_data;
    logic        cfg_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [47:0] exp_q[$];
    logic [47:0] beats[$];
    logic [47:0] last_out = 48'h0;

    always #5 clk = ~clk;

    pool_unit_para_fp16 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .pool_size (pool_size),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .cfg_err   (cfg_err)
    );

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", {47'h0, out_valid}, 48'h0);
            end else begin
                last_out = exp_q.pop_front();
                check("out_data", out_data, last_out);
            end
        end
    end

    task automatic push4(input logic [47:0] b0, input logic [47:0] b1,
                         input logic [47:0] b2, input logic [47:0] b3);
        beats.push_back(b0);
        beats.push_back(b1);
        beats.push_back(b2);
        beats.push_back(b3);
    endtask

    // Drives one window from the beats queue; gap = idle cycles between beats,
    // noise = stray IDLE beat, beat alongside start, and a second start mid-window.
    task automatic run_window(input string tag, input logic m, input logic [2:0] k,
                              input logic [47:0] expv, input int gap, input bit noise);
        int nb;
        nb = beats.size();
        @(posedge clk); #1;
        if (noise) begin
            in_valid = 1'b1;
            in_data  = 48'hDEAD_BEEF_1234;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        start     = 1'b1;
        mode      = m;
        pool_size = k;
        if (noise) begin
            in_valid = 1'b1;
            in_data  = 48'h7BFF_7BFF_7BFF;
        end
        exp_q.push_back(expv);
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < nb; i++) begin
            in_valid = 1'b1;
            in_data  = beats.pop_front();
            if (noise && i == 1) begin
                start     = 1'b1;
                pool_size = 3'd1;
                mode      = ~m;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            start    = 1'b0;
            if (i != nb - 1)
                repeat (gap) begin
                    @(posedge clk); #1;
                end
        end
        @(negedge clk);
        check({tag, "_busy_scale"}, {47'h0, busy}, 48'h1);
        check({tag, "_ov_scale"}, {47'h0, out_valid}, 48'h0);
        @(negedge clk);
        check({tag, "_ov_done"}, {47'h0, out_valid}, 48'h1);
        check({tag, "_busy_done"}, {47'h0, busy}, 48'h0);
        @(posedge clk); #1;
    endtask

    task automatic cfg_bad(input string tag, input logic [2:0] k);
        @(posedge clk); #1;
        start     = 1'b1;
        mode      = 1'b0;
        pool_size = k;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_cfg_err"}, {47'h0, cfg_err}, 48'h1);
        check({tag, "_busy"}, {47'h0, busy}, 48'h0);
        @(posedge clk); #1;
        check({tag, "_cfg_err_clr"}, {47'h0, cfg_err}, 48'h0);
        check({tag, "_busy_after"}, {47'h0, busy}, 48'h0);
        check({tag, "_out_hold"}, out_data, last_out);
    endtask

    task automatic push_t1();
        push4({16'h3C00, 16'h4000, 16'h3C00}, {16'h4200, 16'h4400, 16'h3C00},
              {16'h3C00, 16'h4400, 16'h3C00}, {16'h4200, 16'h4000, 16'h3C00});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        mode      = 1'b0;
        pool_size = 3'd0;
        in_valid  = 1'b0;
        in_data   = 48'h0;
        repeat (2) @(negedge clk);
        check("rst_busy", {47'h0, busy}, 48'h0);
        check("rst_out_valid", {47'h0, out_valid}, 48'h0);
        check("rst_cfg_err", {47'h0, cfg_err}, 48'h0);
        check("rst_out_data", out_data, 48'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Average k=2: lanes 1,1,1,1 / 2,4,4,2 / 1,3,1,3
        push_t1();
        run_window("avg_k2", 1'b0, 3'd2, {16'h4000, 16'h4200, 16'h3C00}, 0, 1'b0);

        // Average k=3, nine 2.0 beats: 18 * RECIP[9] rounds up to exactly 2.0
        for (int i = 0; i < 9; i++) beats.push_back({16'h4000, 16'h4000, 16'h4000});
        run_window("avg_k3", 1'b0, 3'd3, {16'h4000, 16'h4000, 16'h4000}, 0, 1'b0);

        // Max k=2: mixed, all-negative, and -0/+0 tie keeping the first
        push4({16'h8000, 16'hC400, 16'hC000}, {16'h0000, 16'hC000, 16'h3C00},
              {16'hC000, 16'hC200, 16'h8000}, {16'hC400, 16'hBC00, 16'h4200});
        run_window("max_k2", 1'b1, 3'd2, {16'h8000, 16'hBC00, 16'h4200}, 0, 1'b0);

        // Bubbles plus stray inputs give the same result as the clean k=2 window
        push_t1();
        run_window("avg_bubble", 1'b0, 3'd2, {16'h4000, 16'h4200, 16'h3C00}, 2, 1'b1);

        // Average k=1 passes the single beat through
        beats.push_back({16'h4500, 16'hC000, 16'h3555});
        run_window("avg_k1", 1'b0, 3'd1, {16'h4500, 16'hC000, 16'h3555}, 0, 1'b0);

        // Average k=2: saturation on lane2, 9/4 on lane1, exact cancellation to +0 on lane0
        push4({16'h7BFF, 16'h4000, 16'h3C00}, {16'h7BFF, 16'h4000, 16'hBC00},
              {16'h7BFF, 16'h4000, 16'h4000}, {16'h7BFF, 16'h4200, 16'hC000});
        run_window("avg_sat", 1'b0, 3'd2, {16'h73FF, 16'h4080, 16'h0000}, 0, 1'b0);

        // Average k=4: sixteen 1.0 beats -> 16 * 1/16
        for (int i = 0; i < 16; i++) beats.push_back({16'h3C00, 16'h3C00, 16'h3C00});
        run_window("avg_k4", 1'b0, 3'd4, {16'h3C00, 16'h3C00, 16'h3C00}, 0, 1'b0);

        // Max k=4: rising positives, increasingly negative, single peak mid-window
        for (int i = 0; i < 16; i++)
            beats.push_back({16'h3C00 + 16'(i), 16'hC000 + 16'(i), (i == 7) ? 16'h5000 : 16'h3800});
        run_window("max_k4", 1'b1, 3'd4, {16'h3C0F, 16'hC000, 16'h5000}, 1, 1'b0);

        // Illegal sizes
        cfg_bad("cfg0", 3'd0);
        cfg_bad("cfg5", 3'd5);

        // Reset after 2 of 4 beats, then a clean window
        @(posedge clk); #1;
        start     = 1'b1;
        mode      = 1'b0;
        pool_size = 3'd2;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = {16'h7BFF, 16'h7BFF, 16'h7BFF};
        repeat (2) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("midrst_out_data", out_data, 48'h0);
        check("midrst_busy", {47'h0, busy}, 48'h0);
        check("midrst_out_valid", {47'h0, out_valid}, 48'h0);
        last_out = 48'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        push_t1();
        run_window("after_rst", 1'b0, 3'd2, {16'h4000, 16'h4200, 16'h3C00}, 0, 1'b0);

        repeat (5) @(posedge clk);
        check("scoreboard_drained", 48'(exp_q.size()), 48'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pool_unit_para_fp16.md
# pool_unit_para_fp16

Parametrised, multi-lane FP16 pooling unit, the successor to the single-mode average pool unit. It reduces one pooling window per lane to a single value in either average or max mode, with a runtime window size up to `POOL_MAX`×`POOL_MAX`. All `LANES` lanes share one control FSM and consume one sample per lane per accepted beat. It sits between the feature-map read path and the pooled-result writeback in the CNN datapath.

## Interface
- `LANES`, 3, number of parallel lanes (matches `PARA_POOL_Y`).
- `DATA_WIDTH`, 16, IEEE-754 binary16 word width; only 16 supported.
- `POOL_MAX`, 4, largest legal pool edge.
- `POOL_SIZE_WIDTH`, 3, width of `pool_size`; must hold `POOL_MAX`.

Clocking and reset (already decided): one clock; reset is asynchronous and active-high.

- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a window; sampled only in IDLE.
- `mode` in 1: 0 = average, 1 = max; latched on accepted `start`.
- `pool_size` in `POOL_SIZE_WIDTH`: window edge k; latched on accepted `start`; window holds n = k×k samples.
- `in_valid` in 1: `in_data` beat valid.
- `in_data` in `LANES*DATA_WIDTH`: lane i occupies bits [16i+15:16i].
- `busy` out 1: window in progress.
- `out_valid` out 1: one-cycle result strobe.
- `out_data` out `LANES*DATA_WIDTH`: per-lane result.
- `cfg_err` out 1: one-cycle strobe on a rejected `start`.

## Operation
FSM states: IDLE, ACCUM, SCALE, DONE.

- **IDLE**
  - `start`=1 with 1 ≤ `pool_size` ≤ `POOL_MAX`: latch `mode`, latch n, clear the sample counter, go to ACCUM.
  - `start` with illegal `pool_size` (0 or > `POOL_MAX`): stay in IDLE and pulse `cfg_err`.
- **ACCUM**
  - Each cycle with `in_valid`=1 is one beat; bubbles are allowed.
  - The first beat loads each lane accumulator directly.
  - Later beats: avg mode does acc ← fp16_add(acc, x); max mode does acc ← x when x > acc.
  - The counter reaches n on the n-th beat, then the FSM goes to SCALE.
  - `start` is ignored in this state.
- **SCALE**
  - Avg mode: acc ← fp16_mul(acc, RECIP[n]). RECIP is a constant LUT of 1/n rounded-to-nearest-even, for n = 1..`POOL_MAX`².
  - Max mode: acc passes through unchanged.
  - Then go to DONE.
- **DONE**
  - Drive `out_data` ← acc and pulse `out_valid` for one cycle, then return to IDLE.
  - `out_data` holds its value until the next DONE.
- **Arithmetic**
  - Add and multiply round to nearest, ties to even.
  - Subnormal inputs and results flush to signed zero.
  - Overflow saturates to ±0x7BFF.
  - Inf and NaN inputs are unsupported; results for them are undefined but must not hang the FSM.
- **Max compare**
  - Sign-magnitude ordering; +0 and −0 compare equal.
  - On a tie, keep the incumbent value.
- **Other rules**
  - `in_valid` in IDLE, SCALE or DONE is ignored; no beat is consumed.
  - `rst` at any point returns the FSM to IDLE and discards any partial window.

## Timing
- **Reset values:** `busy`=0, `out_valid`=0, `cfg_err`=0, `out_data`=0, FSM in IDLE.
- **Start:** sampled at cycle S. ACCUM is active from S+1, so the earliest accepted beat is at S+1.
- **Result latency:** if the n-th beat is accepted at cycle M, SCALE occurs at M+1 and `out_valid`/`out_data` are valid at M+2.
- **Back-to-back windows:** with no bubbles, a window takes n+3 cycles from `start` to `out_valid`.
- **`busy`:** high S+1 through M+1, low in the DONE cycle. A new `start` is accepted in the cycle after DONE (FSM back in IDLE).
- **`cfg_err`:** high in cycle S+1 for a rejected start.
- **Simultaneous events:** `start` and `in_valid` in the same IDLE cycle: `start` is taken and the beat is dropped.

## Test plan
- **Avg, k=2, 4 beats:** lane0 = 1,1,1,1; lane1 = 2,4,4,2; lane2 = 1,3,1,3 (0x3C00/0x4000/0x4200/0x4400) -> `out_data` = {0x4000, 0x4200, 0x3C00} (lane2..lane0), `out_valid` 2 cycles after the 4th beat.
- **Avg, k=3, nine beats of 2.0 (0x4000) on all lanes:** sum 0x4C80 × RECIP[9] = 0x2F1C -> 0x4000 on every lane (exercises the tie-to-even path).
- **Max, k=2:** lane0 beats 0xC000, 0x3C00, 0x8000, 0x4200 -> 0x4200; a lane with all negative inputs returns the least-negative value; −0/+0 tie keeps the first.
- **Bubbles and stray inputs:** `in_valid` toggled 1,0,0,1,... with k=2 -> result unaffected; `in_valid` pulses in IDLE and a second `start` mid-window are ignored.
- **Config error:** `pool_size`=0 and `pool_size`=5 -> `cfg_err` pulse, `busy` stays 0, `out_data` unchanged.
- **Reset mid-window:** assert `rst` after 2 of 4 beats -> all outputs 0 immediately; the next full window produces the correct, uncontaminated result.
